mmio_bridge: RTL and testbench
==============================

MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter RAM_WORDS, 256, number of 32-bit data RAM words (power of two, ≤256).
REQ-002 Parameter FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 MemWrite  input  1  store strobe from CPU core, valid for the current cycle.
REQ-006 Mem_WrAddr  input  32  byte address of CPU load/store.
REQ-007 Mem_WrData  input  32  CPU store data.
REQ-008 ReadData  output  32  load data to CPU core, combinational from Mem_WrAddr.
REQ-009 leds  output  8  LED register contents.
REQ-010 tx_data  output  8  FIFO head byte.
REQ-011 tx_valid  output  1  FIFO non-empty.
REQ-012 tx_ready  input  1  consumer accepts head when tx_valid&tx_ready at rising edge.
REQ-013 irq  output  1  equals STATUS.hit.

Function
REQ-014 The address map SHALL use Mem_WrAddr[31:2] (word aligned; bits[1:0] ignored):
 - 0x0000_0000..RAM_WORDS*4-1: RAM, index Mem_WrAddr[9:2]; read combinational, write at clock edge.
 - 0x1000 LED (RW, bits[7:0]; reads zero-extended).
 - 0x1004 TCOUNT (read count; any write clears to 0).
 - 0x1008 TCMP (RW, 32 bits).
 - 0x100C STATUS (RO bits below; write with bit0=1 clears hit, bit7=1 clears ovf, bit6=1 clears bad).
 - 0x1010 TXDATA (write pushes Mem_WrData[7:0]; reads 0).
REQ-015 STATUS SHALL be: bit0 hit, bit1 full, bit2 empty, bits[5:3] fifo count (saturating at 7), bit6 bad, bit7 ovf, others 0.
REQ-016 Any access (read or write) to an unmapped address SHALL return ReadData=0, ignore writes, and set sticky bad at the next edge; reads count only when MemWrite=0.
REQ-017 Timer SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF->0; a TCOUNT write SHALL override the increment (count=0 next cycle).
REQ-018 hit SHALL set at the edge where count==TCMP; if set and clear coincide, set wins.
REQ-019 TX FIFO push on TXDATA write; pop on tx_valid&tx_ready; simultaneous push and pop SHALL both take effect, including when full (count unchanged).
REQ-020 Push when full without simultaneous pop SHALL drop the byte and set sticky ovf.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; tx_data SHALL be the head entry, undefined-free (0) when empty.
REQ-022 Read-to-ReadData latency SHALL be zero cycles; write effect visible on ReadData in the cycle after the edge.

Reset
REQ-023 While reset=0: leds=0, TCMP=0, count=0, hit=0, ovf=0, bad=0, FIFO empty (tx_valid=0, tx_data=0), irq=0.
REQ-024 RAM contents SHALL NOT be reset; reads of unwritten RAM are don't-care.
REQ-025 Reset asserted mid-operation SHALL discard FIFO contents and any in-flight handshake immediately.
REQ-026 First post-reset count increment SHALL occur at the first rising edge with reset=1.

Structure
REQ-027 Shared package mmio_pkg SHALL hold address constants (RAM base/size, LED, TCOUNT, TCMP, STATUS, TXDATA) and STATUS bit indices.
REQ-028 The FIFO SHALL be a sub-module tx_fifo (params WIDTH, DEPTH; push, pop, full, empty, count, head).
REQ-029 Address decode, timer, RAM and register file SHALL reside in mmio_bridge.

Verification
REQ-030 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> ReadData=0xDEADBEEF; read 0x0000_0013 -> same.
REQ-031 Write TCMP=5, TCOUNT write at cycle 0 -> count reads 0..5, hit/irq=1 from the edge count==5; STATUS write 0x1 same cycle count==TCMP -> hit stays 1.
REQ-032 tx_ready=0, push 0x41..0x45 -> full=1 after four, 0x45 dropped, ovf=1; then tx_ready=1 -> tx_data 0x41,0x42,0x43,0x44 on successive cycles, then tx_valid=0.
REQ-033 FIFO full with tx_ready=1 and push 0x55 same cycle -> count stays 4, 0x55 appears last.
REQ-034 Read 0x2000 -> ReadData=0, bad=1; write 0x40 to STATUS -> bad=0.
REQ-035 Assert reset=0 with FIFO holding 3 bytes and leds=0xA5 -> tx_valid=0, leds=0, STATUS=0x04 immediately, without waiting for clk.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - address map, STATUS bit layout and helpers shared by the MMIO bridge
//
// Purpose: single source for the bridge's byte addresses, RAM sizing default and
// STATUS register bit positions, used by the RTL and by anything that drives it.
// Ports: none (package).

package mmio_pkg;

  // RAM occupies the bottom of the map; the bridge parameter sets its actual size.
  localparam logic [31:0] ADDR_RAM_BASE  = 32'h0000_0000;
  localparam int          RAM_WORDS_DEF  = 256;
  localparam int          RAM_WORDS_MAX  = 256;

  localparam logic [31:0] ADDR_LED       = 32'h0000_1000;
  localparam logic [31:0] ADDR_TCOUNT    = 32'h0000_1004;
  localparam logic [31:0] ADDR_TCMP      = 32'h0000_1008;
  localparam logic [31:0] ADDR_STATUS    = 32'h0000_100C;
  localparam logic [31:0] ADDR_TXDATA    = 32'h0000_1010;

  // STATUS layout; the write-1-to-clear bits share the same positions.
  localparam int ST_HIT     = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_CNT_LSB = 3;
  localparam int ST_BAD     = 6;
  localparam int ST_OVF     = 7;

  // FIFO occupancy as shown in STATUS: three bits, pinned at 7 for deeper FIFOs.
  function automatic logic [2:0] sat_count3(input logic [31:0] c);
    return (c > 32'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - circular-buffer transmit FIFO with registered pointers
//
// Purpose: holds bytes written by the CPU until the consumer takes them.
// Ports:
//   clk, reset       clock, asynchronous active-low reset (pointers/count only)
//   push, din        enqueue request and data
//   pop              dequeue request (ignored when empty)
//   full, empty      occupancy flags
//   count            number of entries held (0..DEPTH)
//   head             oldest entry, forced to 0 when empty

module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign count = cnt_q;
  assign head  = empty ? '0 : mem_q[rd_q];

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle: the write lands in the slot being vacated.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop_ok)  rd_d = rd_q + PW'(1);
    if (push_ok) wr_d = wr_q + PW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (PW+1)'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; emptiness is carried entirely by the count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU load/store bridge to data RAM, LEDs, timer and TX FIFO
//
// Purpose: decodes the CPU data-bus address into RAM and a small register file,
// runs a free-running timer with compare interrupt and feeds a byte TX FIFO.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   MemWrite, Mem_WrAddr,
//   Mem_WrData                   CPU store strobe, byte address, store data
//   ReadData                     combinational load data for Mem_WrAddr
//   leds                         LED register
//   tx_data, tx_valid, tx_ready  FIFO head stream towards the consumer
//   irq                          timer compare hit flag

module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS  = RAM_WORDS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  // Byte lanes are not decoded; accesses are always whole words.
  logic [29:0]      word_addr;
  logic [IDX_W-1:0] ram_idx;
  logic             unused_addr_lsbs;

  assign word_addr        = Mem_WrAddr[31:2];
  assign ram_idx          = Mem_WrAddr[IDX_W+1:2];
  assign unused_addr_lsbs = ^Mem_WrAddr[1:0];

  logic ram_sel, led_sel, tcount_sel, tcmp_sel, status_sel, txdata_sel, unmapped;

  always_comb begin
    ram_sel    = (word_addr < 30'(RAM_WORDS));
    led_sel    = (word_addr == ADDR_LED[31:2]);
    tcount_sel = (word_addr == ADDR_TCOUNT[31:2]);
    tcmp_sel   = (word_addr == ADDR_TCMP[31:2]);
    status_sel = (word_addr == ADDR_STATUS[31:2]);
    txdata_sel = (word_addr == ADDR_TXDATA[31:2]);
    unmapped   = ~(ram_sel | led_sel | tcount_sel | tcmp_sel | status_sel | txdata_sel);
  end

  // Register state
  logic [7:0]  leds_q, leds_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [31:0] count_q, count_d;
  logic        hit_q, hit_d;
  logic        ovf_q, ovf_d;
  logic        bad_q, bad_d;

  // FIFO interface
  logic          fifo_full, fifo_empty, tx_push, tx_pop;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;

  assign tx_push = MemWrite & txdata_sel;
  assign tx_pop  = ~fifo_empty & tx_ready;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (Mem_WrData[7:0]),
    .pop   (tx_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  logic clr_hit, clr_ovf, clr_bad;

  assign clr_hit = MemWrite & status_sel & Mem_WrData[ST_HIT];
  assign clr_ovf = MemWrite & status_sel & Mem_WrData[ST_OVF];
  assign clr_bad = MemWrite & status_sel & Mem_WrData[ST_BAD];

  always_comb begin
    leds_d = leds_q;
    tcmp_d = tcmp_q;
    if (MemWrite && led_sel)  leds_d = Mem_WrData[7:0];
    if (MemWrite && tcmp_sel) tcmp_d = Mem_WrData;

    // A TCOUNT write takes priority over the free-running increment.
    count_d = (MemWrite && tcount_sel) ? 32'd0 : count_q + 32'd1;

    // Sticky flags: a set in the same cycle as its clear wins.
    hit_d = (count_q == tcmp_q) | (hit_q & ~clr_hit);
    ovf_d = (tx_push & fifo_full & ~tx_pop) | (ovf_q & ~clr_ovf);
    bad_d = unmapped | (bad_q & ~clr_bad);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q  <= '0;
      tcmp_q  <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      leds_q  <= leds_d;
      tcmp_q  <= tcmp_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  // Data RAM: no reset, written on the edge, read combinationally.
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) ram_q[ram_idx] <= Mem_WrData;
  end

  logic [31:0] status;

  always_comb begin
    status                        = '0;
    status[ST_HIT]                = hit_q;
    status[ST_FULL]               = fifo_full;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_CNT_LSB +: 3]       = sat_count3(32'(fifo_count));
    status[ST_BAD]                = bad_q;
    status[ST_OVF]                = ovf_q;
  end

  // TXDATA and unmapped addresses read as zero via the default.
  always_comb begin
    ReadData = '0;
    if (ram_sel)         ReadData = ram_q[ram_idx];
    else if (led_sel)    ReadData = {24'd0, leds_q};
    else if (tcount_sel) ReadData = count_q;
    else if (tcmp_sel)   ReadData = tcmp_q;
    else if (status_sel) ReadData = status;
  end

  assign leds     = leds_q;
  assign tx_data  = fifo_head;
  assign tx_valid = ~fifo_empty;
  assign irq      = hit_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge with a TX byte scoreboard

module tb_mmio_bridge;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];
  logic [7:0] mon_b;

  always #10 clk = ~clk;

  mmio_bridge #(
    .RAM_WORDS  (256),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .leds       (leds),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Mem_WrAddr = a;
    Mem_WrData = d;
    MemWrite   = 1'b1;
    @(posedge clk); #1;
    MemWrite   = 1'b0;
    Mem_WrAddr = 32'h0;
    Mem_WrData = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Mem_WrAddr = a;
    #1;
    check(tag, ReadData, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard: pushes are modelled when the write is on the bus, pops are
  // compared against the head at the handshake; sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
      if (tx_ready && exp_q.size() != 0) begin
        mon_b = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(mon_b));
      end
      if (MemWrite && Mem_WrAddr[31:2] == ADDR_TXDATA[31:2]) begin
        if (exp_q.size() < 4) exp_q.push_back(Mem_WrData[7:0]);
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    reset      = 1'b0;
    MemWrite   = 1'b0;
    Mem_WrAddr = ADDR_STATUS;
    Mem_WrData = 32'h0;
    tx_ready   = 1'b0;
    step(2);

    // Reset state
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_txv", 32'(tx_valid), 32'h0);
    check("rst_txd", 32'(tx_data), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_status", ADDR_STATUS, 32'h04);

    // First increment on the first edge after release; count==TCMP==0 sets hit there
    Mem_WrAddr = ADDR_TCOUNT;
    reset      = 1'b1;
    #1;
    check("cnt_pre", ReadData, 32'd0);
    step(1);
    check("cnt_first", ReadData, 32'd1);
    check("irq_boot", 32'(irq), 32'h1);

    // Timer compare
    wr(ADDR_TCMP, 32'd5);
    wr(ADDR_STATUS, 32'h1);
    check("hit_clr", 32'(irq), 32'h0);
    wr(ADDR_TCOUNT, 32'hFFFF_FFFF);
    for (int i = 0; i <= 5; i++) begin
      rd_chk($sformatf("cnt_%0d", i), ADDR_TCOUNT, 32'(i));
      check($sformatf("irq_lo_%0d", i), 32'(irq), 32'h0);
      step(1);
    end
    check("irq_hit", 32'(irq), 32'h1);
    rd_chk("status_hit", ADDR_STATUS, 32'h05);
    wr(ADDR_STATUS, 32'h1);
    wr(ADDR_TCOUNT, 32'h0);
    step(5);
    rd_chk("cnt_5b", ADDR_TCOUNT, 32'd5);
    wr(ADDR_STATUS, 32'h1);
    check("hit_set_wins", 32'(irq), 32'h1);
    wr(ADDR_STATUS, 32'h1);
    check("hit_clr2", 32'(irq), 32'h0);

    // RAM, LED and register reads
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
    wr(32'h0000_03FC, 32'h1234_5678);
    rd_chk("ram_top", 32'h0000_03FC, 32'h1234_5678);
    rd_chk("ram_10b", 32'h0000_0010, 32'hDEAD_BEEF);
    wr(ADDR_LED, 32'hFFFF_FFA5);
    check("leds", 32'(leds), 32'hA5);
    rd_chk("led_rd", ADDR_LED, 32'h0000_00A5);
    rd_chk("txdata_rd", ADDR_TXDATA, 32'h0);
    rd_chk("tcmp_rd", ADDR_TCMP, 32'd5);

    // FIFO fill, overflow, drain
    tx_ready = 1'b0;
    for (int b = 8'h41; b <= 8'h44; b++) wr(ADDR_TXDATA, 32'(b));
    rd_chk("fifo_full", ADDR_STATUS, 32'h22);
    wr(ADDR_TXDATA, 32'h45);
    rd_chk("fifo_ovf", ADDR_STATUS, 32'hA2);
    wr(ADDR_STATUS, 32'h80);
    rd_chk("ovf_clr", ADDR_STATUS, 32'h22);
    tx_ready = 1'b1;
    step(4);
    check("drained", 32'(tx_valid), 32'h0);
    rd_chk("status_empty", ADDR_STATUS, 32'h04);

    // Push and pop together while full
    tx_ready = 1'b0;
    for (int b = 8'h51; b <= 8'h54; b++) wr(ADDR_TXDATA, 32'(b));
    rd_chk("full2", ADDR_STATUS, 32'h22);
    tx_ready = 1'b1;
    wr(ADDR_TXDATA, 32'h55);
    tx_ready = 1'b0;
    rd_chk("full_pushpop", ADDR_STATUS, 32'h22);
    tx_ready = 1'b1;
    step(4);
    tx_ready = 1'b0;
    check("drained2", 32'(tx_valid), 32'h0);

    // Unmapped accesses
    rd_chk("unmapped_rd", 32'h0000_2000, 32'h0);
    step(1);
    rd_chk("bad_set", ADDR_STATUS, 32'h44);
    wr(ADDR_STATUS, 32'h40);
    rd_chk("bad_clr", ADDR_STATUS, 32'h04);
    wr(32'h0000_1014, 32'h77);
    rd_chk("bad_wr", ADDR_STATUS, 32'h44);
    check("leds_kept", 32'(leds), 32'hA5);
    wr(ADDR_STATUS, 32'h40);

    // Asynchronous reset mid-operation
    for (int b = 8'h61; b <= 8'h63; b++) wr(ADDR_TXDATA, 32'(b));
    check("pre_rst_valid", 32'(tx_valid), 32'h1);
    Mem_WrAddr = ADDR_STATUS;
    reset      = 1'b0;
    exp_q.delete();
    #1;
    check("arst_txv", 32'(tx_valid), 32'h0);
    check("arst_txd", 32'(tx_data), 32'h0);
    check("arst_leds", 32'(leds), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_status", ReadData, 32'h04);
    step(2);
    reset = 1'b1;
    step(1);
    check("post_rst_txv", 32'(tx_valid), 32'h0);
    rd_chk("post_rst_tcmp", ADDR_TCMP, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
